// File: rtl/router_fifo_pkg.sv
// rtl/router_fifo_pkg.sv - shared router constants and header length helper
package router_fifo_pkg;

    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 8;
    localparam int PTR_W      = ADDR_W + 1;
    localparam int CNT_W      = 7;
    localparam int LEN_MSB    = 7;
    localparam int LEN_LSB    = 2;

    // Stored word: header flag on top of the data byte
    typedef logic [DATA_W:0] fifo_word_t;

    // Bytes still to come after a header: payload length plus the parity byte
    function automatic logic [CNT_W-1:0] pkt_len(input logic [DATA_W-1:0] hdr);
        return CNT_W'(hdr[LEN_MSB:LEN_LSB]) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - 16x9 output-channel FIFO with packet byte counter
module router_fifo
    import router_fifo_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_busy
);

    fifo_word_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              lfd_q, lfd_d;
    logic              rst;
    logic              wr_accept;
    logic              rd_accept;
    fifo_word_t        rd_word;

    // Hard and soft reset share one path; neither outranks the other
    assign rst       = !resetn || soft_reset;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                       (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign wr_accept = write_enb && !full;
    assign rd_accept = read_enb && !empty;
    assign rd_word   = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign data_out  = data_out_q;
    assign pkt_busy  = (count_q != '0);

    // Next-state for pointers, counter, output byte and delayed header flag
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        lfd_d      = lfd_state;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_accept) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            data_out_d = rd_word[DATA_W-1:0];
            if (rd_word[DATA_W]) begin
                count_d = pkt_len(rd_word[DATA_W-1:0]);
            end else if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        if (rst) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            data_out_d = '0;
            lfd_d      = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clock) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        data_out_q <= data_out_d;
        lfd_q      <= lfd_d;
    end

    // Storage is not cleared; empty hides stale words after reset
    always_ff @(posedge clock) begin
        if (wr_accept && !rst) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {lfd_q, data_in};
        end
    end

endmodule

// File: tb/tb_router_fifo.sv
// tb/tb_router_fifo.sv - randomized model-checked bench for router_fifo
module tb_router_fifo;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       pkt_busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [8:0] m_q[$];
    logic       m_lfd  = 1'b0;
    int         m_cnt  = 0;
    logic [7:0] m_dout = 8'h00;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty),
        .pkt_busy   (pkt_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, counter as plain integer arithmetic
    always @(posedge clock) begin
        logic       wa, ra;
        logic [8:0] w;
        if (!resetn || soft_reset) begin
            m_q.delete();
            m_lfd  = 1'b0;
            m_cnt  = 0;
            m_dout = 8'h00;
        end else begin
            wa = write_enb && (m_q.size() < 16);
            ra = read_enb && (m_q.size() > 0);
            if (ra) begin
                w = m_q.pop_front();
                m_dout = w[7:0];
                if (w[8]) m_cnt = int'(w[7:0]) / 4 + 1;
                else if (m_cnt > 0) m_cnt = m_cnt - 1;
            end
            if (wa) m_q.push_back({m_lfd, data_in});
            m_lfd = lfd_state;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clock) begin
        check("empty",    {31'b0, empty},    {31'b0, m_q.size() == 0});
        check("full",     {31'b0, full},     {31'b0, m_q.size() == 16});
        check("pkt_busy", {31'b0, pkt_busy}, {31'b0, m_cnt != 0});
        check("data_out", {24'b0, data_out}, {24'b0, m_dout});
    end

    task automatic cyc(input logic we, input logic [7:0] din, input logic lfd,
                       input logic re, input logic srst = 1'b0, input logic rn = 1'b1);
        write_enb  = we;
        data_in    = din;
        lfd_state  = lfd;
        read_enb   = re;
        soft_reset = srst;
        resetn     = rn;
        @(negedge clock);
    endtask

    logic [7:0] pkt[5];
    logic [7:0] orig[16];
    int         exp_cnt[5];

    initial begin
        pkt     = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h1F};
        exp_cnt = '{4, 3, 2, 1, 0};

        // Reset
        cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_empty", {31'b0, empty}, 32'd1);
        check("rst_full",  {31'b0, full},  32'd0);
        check("rst_busy",  {31'b0, pkt_busy}, 32'd0);
        check("rst_dout",  {24'b0, data_out}, 32'h00);

        // Packet: header flagged via delayed lfd, then read back with counter
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, pkt[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            check("pkt_dout", {24'b0, data_out}, {24'b0, pkt[i]});
            check("pkt_cnt",  32'(dut.count_q), exp_cnt[i]);
        end
        check("pkt_empty", {31'b0, empty}, 32'd1);
        check("pkt_busy0", {31'b0, pkt_busy}, 32'd0);

        // Full: pointer wrap, 17th write ignored, write blocked while full
        for (int i = 0; i < 16; i++) begin
            orig[i] = 8'($urandom);
            cyc(1'b1, orig[i], 1'b0, 1'b0);
            check("fill_full", {31'b0, full}, {31'b0, i == 15});
        end
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("full_hold", {31'b0, full}, 32'd1);
        cyc(1'b1, 8'hBB, 1'b0, 1'b1);
        check("full_rd", {24'b0, data_out}, {24'b0, orig[0]});
        check("full_clr", {31'b0, full}, 32'd0);
        for (int i = 1; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b1);
            check("wrap_order", {24'b0, data_out}, {24'b0, orig[i]});
        end
        check("wrap_empty", {31'b0, empty}, 32'd1);

        // Simultaneous read/write at occupancy 8
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b1);
            check("sim_order", {24'b0, data_out}, {24'b0, 8'(8'h40 + i)});
        end
        check("sim_occ", 32'(m_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("sim_last", {24'b0, data_out}, 32'h83);

        // Soft reset mid-packet
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b1, 8'h08, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b0, 1'b0);
        cyc(1'b1, 8'h02, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("sr_busy1", {31'b0, pkt_busy}, 32'd1);
        cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        check("sr_empty", {31'b0, empty}, 32'd1);
        check("sr_busy0", {31'b0, pkt_busy}, 32'd0);
        check("sr_dout",  {24'b0, data_out}, 32'h00);

        // Read while empty holds data_out
        cyc(1'b1, 8'h33, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("er_dout1", {24'b0, data_out}, 32'h33);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("er_dout2", {24'b0, data_out}, 32'h33);
        check("er_empty", {31'b0, empty}, 32'd1);

        // Randomized traffic with write-heavy / read-heavy phases and rare resets
        for (int i = 0; i < 3000; i++) begin
            logic wbias;
            wbias = ((i / 64) % 2) == 0;
            cyc($urandom_range(0, 3) != 0 ? wbias : !wbias,
                8'($urandom),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) != 0 ? !wbias : wbias,
                $urandom_range(0, 149) == 0,
                $urandom_range(0, 299) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_fifo.md
ROUTER_FIFO -- requirements
Module: router_fifo

Interface
REQ-001 SHALL have ports: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL have ports: resetn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: soft_reset  in  1  synchronous flush of this output channel, active-high.
REQ-004 SHALL have ports: write_enb  in  1  write request from register stage.
REQ-005 SHALL have ports: lfd_state  in  1  load-first-data indicator from router FSM.
REQ-006 SHALL have ports: data_in  in  8  byte from register stage dout.
REQ-007 SHALL have ports: read_enb  in  1  read request from destination.
REQ-008 SHALL have ports: data_out  out  8  registered popped byte.
REQ-009 SHALL have ports: full  out  1  16 words stored.
REQ-010 SHALL have ports: empty  out  1  0 words stored.
REQ-011 SHALL have ports: pkt_busy  out  1  packet counter non-zero.

Function
REQ-012 SHALL store 16 words of 9 bits: bit 8 = header flag, bits 7:0 = data byte.
REQ-013 SHALL register lfd_state into lfd_d each cycle; header flag written = lfd_d, since the register stage emits the header one cycle after lfd_state.
REQ-014 SHALL accept a write iff write_enb && !full: mem[wr_ptr] <= {lfd_d, data_in}, wr_ptr += 1.
REQ-015 SHALL accept a read iff read_enb && !empty: data_out <= mem[rd_ptr][7:0], rd_ptr += 1; data_out valid the cycle after acceptance.
REQ-016 SHALL hold data_out unchanged on cycles with no accepted read.
REQ-017 SHALL use 5-bit pointers; addresses = bits 3:0, wrap 15->0 with bit 4 toggling.
REQ-018 SHALL drive empty = (wr_ptr == rd_ptr), full = (addresses equal, bit 4 differs), both combinational from registered pointers.
REQ-019 SHALL accept simultaneous read and write when neither flag blocks; occupancy unchanged.
REQ-020 SHALL ignore write_enb while full even if a read is accepted the same cycle; SHALL ignore read_enb while empty even if a write is accepted the same cycle.
REQ-021 SHALL keep a 7-bit packet counter: on accepted read of a word with flag=1, count <= word[7:2] + 1 (payload + parity).
REQ-022 SHALL decrement count by 1 on accepted read of a flag=0 word when count > 0; flag=0 read at count 0 leaves count 0.
REQ-023 SHALL drive pkt_busy = (count != 0).
REQ-024 SHALL treat soft_reset identically to reset (REQ-025) and give it no priority over resetn; both asserted = reset.

Reset
REQ-025 SHALL, when resetn=0 or soft_reset=1, at the clock edge set wr_ptr=0, rd_ptr=0, count=0, lfd_d=0, data_out=8'h00; thus empty=1, full=0, pkt_busy=0.
REQ-026 SHALL NOT require memory contents cleared; no stale word is observable after reset because empty=1.
REQ-027 SHALL, on reset mid-packet, discard all stored words; writes/reads in the reset cycle are ignored.

Structure
REQ-028 SHALL take FIFO_DEPTH=16, ADDR_W=4, DATA_W=8, and length-field position [7:2] from the shared router package.
REQ-029 SHALL be one flat module; no sub-module, as storage, pointers and counter are tightly coupled.

Verification
REQ-030 Reset: resetn=0 one cycle -> empty=1, full=0, pkt_busy=0, data_out=00.
REQ-031 Packet: lfd_state=1 for one cycle, then write 0x0D, 11, 22, 33, parity 0x1F; read 5 -> data_out 0D,11,22,33,1F; count 4 after header, then 3,2,1,0; empty=1, pkt_busy=0 at end.
REQ-032 Full: 16 writes -> full=1 after 16th; 17th write (0xAA) ignored; one read -> full=0; all 16 originals read back in order across pointer wrap.
REQ-033 Simultaneous: occupancy 8, read_enb=write_enb=1 for 4 cycles -> occupancy 8, FIFO order preserved.
REQ-034 Soft reset: after header + 2 payload written and header read, pulse soft_reset -> empty=1, pkt_busy=0, data_out=00 next cycle.
REQ-035 Empty read: read_enb=1 while empty with data_out=0x33 -> data_out stays 33, pointers unchanged.
